// File: rtl/disp_scan_ctrl.sv
// Two-digit 7-segment scan controller with a one-entry pending buffer committed at frame boundaries.
// Optional blink support is compiled in when DISP_SCAN_BLINK_EN is defined.
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  output logic [6:0] seg,
`ifdef DISP_SCAN_BLINK_EN
  input  logic       blink,
`endif
  output logic [1:0] dig_en
);

  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SCAN0, SCAN1} state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [4:0]  pending_q, pending_d;
  logic        pending_full_q, pending_full_d;
  logic [4:0]  active_q, active_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  dig_en_q, dig_en_d;
  logic        accept, commit, frame_end, blank_d;
  logic [6:0]  units_pat, tens_pat;

`ifdef DISP_SCAN_BLINK_EN
  localparam logic [15:0] FRAME_LAST = 16'(BLINK_FRAMES - 1);
  logic [15:0] frame_q, frame_d;
  logic        phase_q, phase_d;
`endif

  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0:    digit_pat = 7'b0000001;
      4'd1:    digit_pat = 7'b1001111;
      4'd2:    digit_pat = 7'b0010010;
      4'd3:    digit_pat = 7'b0000110;
      4'd4:    digit_pat = 7'b1001100;
      4'd5:    digit_pat = 7'b0100100;
      4'd6:    digit_pat = 7'b0100000;
      4'd7:    digit_pat = 7'b0001111;
      4'd8:    digit_pat = 7'b0000000;
      4'd9:    digit_pat = 7'b0000100;
      default: digit_pat = SEG_BLANK;
    endcase
  endfunction

  assign in_ready = !pending_full_q;
  assign accept   = in_valid && !pending_full_q;

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    commit         = 1'b0;
    frame_end      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_full_q) begin
          commit  = 1'b1;
          state_d = SCAN0;
          div_d   = '0;
        end
      end
      SCAN0: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SCAN1;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      SCAN1: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          state_d   = SCAN0;
          frame_end = 1'b1;
          commit    = pending_full_q;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // accept needs an empty buffer and commit needs a full one, so they never overlap
    if (commit) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept) begin
      pending_d      = in_data;
      pending_full_d = 1'b1;
    end
  end

`ifdef DISP_SCAN_BLINK_EN
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (!blink) begin
      frame_d = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = !phase_q;
      end else begin
        frame_d = frame_q + 16'd1;
      end
    end
  end
  assign blank_d = blink && phase_d;
`else
  assign blank_d = 1'b0;
`endif

  // Outputs are decoded from next-state values so they move on the same edge as the slot
  always_comb begin
    units_pat = SEG_BLANK;
    tens_pat  = SEG_BLANK;
    if (active_d < 5'd10) begin
      units_pat = digit_pat(active_d[3:0]);
    end else if (active_d < 5'd16) begin
      units_pat = digit_pat(active_d[3:0] - 4'd10);
      tens_pat  = digit_pat(4'd1);
    end

    seg_d    = SEG_BLANK;
    dig_en_d = 2'b11;
    if (!blank_d) begin
      case (state_d)
        SCAN0: begin
          seg_d    = units_pat;
          dig_en_d = 2'b10;
        end
        SCAN1: begin
          seg_d    = tens_pat;
          dig_en_d = 2'b01;
        end
        default: begin
          seg_d    = SEG_BLANK;
          dig_en_d = 2'b11;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      div_q          <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= '0;
      seg_q          <= SEG_BLANK;
      dig_en_q       <= 2'b11;
`ifdef DISP_SCAN_BLINK_EN
      frame_q        <= '0;
      phase_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      seg_q          <= seg_d;
      dig_en_q       <= dig_en_d;
`ifdef DISP_SCAN_BLINK_EN
      frame_q        <= frame_d;
      phase_q        <= phase_d;
`endif
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule
